split_check_sched: RTL

//   Round-robin scheduler that shares one pipelined split-constraint checker among NREQ requesters.

---
 rtl/split_sched_pkg.sv | 30 +++
 rtl/split_check_pipe.sv | 51 +++++
 rtl/split_check_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/split_sched_pkg.sv
// Shared types and constants for the split-constraint checker scheduler.
// Optional statistics are enabled by SPLIT_SCHED_STATS_EN in split_check_sched.
package split_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    RESP     = 2'd2
  } slot_state_e;

  localparam logic [31:0] FORBID_DEFAULT = 32'h6839A06F;

  // Tag width covers the largest supported requester count (16).
  localparam int ID_W = 4;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            sat;
  } pipe_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    if (cnt == 32'hFFFF_FFFF) begin
      return cnt;
    end else begin
      return cnt + 32'd1;
    end
  endfunction

endpackage

// File: rtl/split_check_pipe.sv
// Pipelined split-constraint checker: compare in stage 0, then a plain shift
// register; the exit is consumed by the scheduler's result registers.
module split_check_pipe
  import split_sched_pkg::*;
#(
  parameter int              W      = 32,
  parameter int              LAT    = 2,
  parameter logic [W-1:0]    FORBID = FORBID_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  input  logic [W-1:0]    in_data,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id,
  output logic            out_sat
);

  pipe_entry_t stage0_s;
  pipe_entry_t exit_s;

  assign stage0_s.vld = in_vld;
  assign stage0_s.id  = in_id;
  assign stage0_s.sat = (in_data != FORBID);

  // The scheduler's result register is the last latency stage, so only LAT-1 stages live here.
  generate
    if (LAT == 1) begin : g_comb
      assign exit_s = stage0_s;
    end else begin : g_regs
      pipe_entry_t pipe_q [LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < LAT-1; k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= stage0_s;
          for (int k = 1; k < LAT-1; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end

      assign exit_s = pipe_q[LAT-2];
    end
  endgenerate

  assign out_vld = exit_s.vld;
  assign out_id  = exit_s.id;
  assign out_sat = exit_s.sat;

endmodule

// File: rtl/split_check_sched.sv
// Round-robin scheduler sharing one split-constraint checker among NREQ requesters.
// Define SPLIT_SCHED_STATS_EN to add saturating sat_cnt/unsat_cnt verdict counters.
module split_check_sched
  import split_sched_pkg::*;
#(
  parameter int           NREQ   = 4,
  parameter int           W      = 32,
  parameter int           LAT    = 2,
  parameter logic [W-1:0] FORBID = FORBID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ-1:0]   rsp_sat,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy
`ifdef SPLIT_SCHED_STATS_EN
  ,
  output logic [31:0]       sat_cnt,
  output logic [31:0]       unsat_cnt
`endif
);

  localparam int PTR_W = $clog2(NREQ);

  slot_state_e       state_q [NREQ];
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [NREQ-1:0]   rsp_sat_q;

  logic [NREQ-1:0]   elig_s;
  logic [NREQ-1:0]   grant_s;
  logic              grant_vld_s;
  logic [PTR_W-1:0]  grant_idx_s;
  logic [PTR_W-1:0]  next_ptr_s;
  logic [NREQ-1:0]   busy_vec_s;

  logic              exit_vld_s;
  logic [ID_W-1:0]   exit_id_s;
  logic              exit_sat_s;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  // Eligibility and busy decode from registered slot states.
  always_comb begin
    elig_s     = '0;
    busy_vec_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i]     = req_valid[i] && (state_q[i] == IDLE);
      busy_vec_s[i] = (state_q[i] != IDLE);
    end
  end

  // Round-robin pick: first eligible index at or after rr_ptr, with wrap.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld_s && elig_s[rr_index(rr_ptr_q, k)]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = rr_index(rr_ptr_q, k);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (grant_vld_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign next_ptr_s = rr_index(grant_idx_s, 1);

  split_check_pipe #(
    .W      (W),
    .LAT    (LAT),
    .FORBID (FORBID)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (grant_vld_s),
    .in_id   (ID_W'(grant_idx_s)),
    .in_data (req_data[int'(grant_idx_s)*W +: W]),
    .out_vld (exit_vld_s),
    .out_id  (exit_id_s),
    .out_sat (exit_sat_s)
  );

  // Per-slot FSMs, round-robin pointer and registered verdicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) state_q[i] <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_sat_q   <= '0;
    end else begin
      if (grant_vld_s) begin
        rr_ptr_q <= next_ptr_s;
      end else begin
        rr_ptr_q <= rr_ptr_q;
      end
      for (int i = 0; i < NREQ; i++) begin
        case (state_q[i])
          IDLE: begin
            if (grant_s[i]) state_q[i] <= INFLIGHT;
            else            state_q[i] <= IDLE;
          end
          INFLIGHT: begin
            if (exit_vld_s && (exit_id_s == ID_W'(i))) begin
              state_q[i]     <= RESP;
              rsp_valid_q[i] <= 1'b1;
              rsp_sat_q[i]   <= exit_sat_s;
            end else begin
              state_q[i] <= INFLIGHT;
            end
          end
          RESP: begin
            if (rsp_ready[i]) begin
              state_q[i]     <= IDLE;
              rsp_valid_q[i] <= 1'b0;
            end else begin
              state_q[i] <= RESP;
            end
          end
          default: begin
            state_q[i]     <= IDLE;
            rsp_valid_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sat   = rsp_sat_q;
  assign busy      = |busy_vec_s;

`ifdef SPLIT_SCHED_STATS_EN
  logic [31:0] sat_cnt_q;
  logic [31:0] unsat_cnt_q;

  // Verdict counters at the pipeline exit; one path, so at most one moves per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q   <= 32'd0;
      unsat_cnt_q <= 32'd0;
    end else if (exit_vld_s) begin
      if (exit_sat_s) sat_cnt_q   <= sat_inc(sat_cnt_q);
      else            unsat_cnt_q <= sat_inc(unsat_cnt_q);
    end else begin
      sat_cnt_q   <= sat_cnt_q;
      unsat_cnt_q <= unsat_cnt_q;
    end
  end

  assign sat_cnt   = sat_cnt_q;
  assign unsat_cnt = unsat_cnt_q;
`endif

endmodule
